// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: pipeline status in, stage-register enables/clears out.
// master = pipeline/controller side, slave = hazard unit.
interface hazard_unit_mc_if #(
    parameter int RA_W  = 4,
    parameter int NSRC  = 3,
    parameter int CNT_W = 16
);
    logic [NSRC*RA_W-1:0] RAD;
    logic [NSRC*RA_W-1:0] RAE;
    logic [RA_W-1:0]      WA3E;
    logic [RA_W-1:0]      WA3M;
    logic [RA_W-1:0]      WA3W;
    logic                 MemtoRegE;
    logic                 MemtoRegM;
    logic                 RegWriteM;
    logic                 RegWriteW;
    logic                 PCWrD;
    logic                 CondExE;
    logic                 BranchTakenE;
    logic                 MemAccessM;
    logic                 MemReadyM;
    logic                 StallF;
    logic                 StallD;
    logic                 StallE;
    logic                 StallM;
    logic                 FlushD;
    logic                 FlushE;
    logic                 FlushW;
    logic [2*NSRC-1:0]    ForwardE;
    logic                 MemTimeout;
    logic [CNT_W-1:0]     StallCount;
    logic [CNT_W-1:0]     FlushCount;

    modport master (
        output RAD, RAE, WA3E, WA3M, WA3W,
        output MemtoRegE, MemtoRegM, RegWriteM, RegWriteW,
        output PCWrD, CondExE, BranchTakenE, MemAccessM, MemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, ForwardE,
        input  MemTimeout, StallCount, FlushCount
    );

    modport slave (
        input  RAD, RAE, WA3E, WA3M, WA3W,
        input  MemtoRegE, MemtoRegM, RegWriteM, RegWriteW,
        input  PCWrD, CondExE, BranchTakenE, MemAccessM, MemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, ForwardE,
        output MemTimeout, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage F/D/E/M/W pipeline: forwarding, load-use,
// PC-write tracking, memory-wait stall with timeout and perf counters.
module hazard_unit_mc #(
    parameter int RA_W    = 4,
    parameter int NSRC    = 3,
    parameter int LDR_LAT = 1,
    parameter int PC_IDX  = 15,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             reset,
    hazard_unit_mc_if.slave hz
);
    localparam int WC_W = $clog2(TIMEOUT) + 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT - 1);
    localparam logic [RA_W-1:0] PC_A   = RA_W'(PC_IDX);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t            state;
    logic [WC_W-1:0]   wait_cnt;
    logic              mem_timeout;
    logic [2:0]        pend;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic              ld_stall;
    logic              mem_stall;
    logic              m_block;
    logic              pcwr;
    logic              stall_f;
    logic              flush_d;
    logic              flush_e;
    logic [2*NSRC-1:0] fwd;

    // With a 2-cycle load, M-stage load data is not ready to forward
    assign m_block = (LDR_LAT == 2) && hz.MemtoRegM;

    always_comb begin
        ld_stall = 1'b0;
        fwd      = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (hz.RAD[i*RA_W +: RA_W] != PC_A) begin
                if (hz.MemtoRegE &&
                    hz.RAD[i*RA_W +: RA_W] == hz.WA3E)
                    ld_stall = 1'b1;
                if (m_block &&
                    hz.RAD[i*RA_W +: RA_W] == hz.WA3M)
                    ld_stall = 1'b1;
            end
            if (hz.RAE[i*RA_W +: RA_W] != PC_A) begin
                if (hz.RegWriteM && !m_block &&
                    hz.RAE[i*RA_W +: RA_W] == hz.WA3M)
                    fwd[2*i +: 2] = 2'b10;
                else if (hz.RegWriteW &&
                         hz.RAE[i*RA_W +: RA_W] == hz.WA3W)
                    fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    assign mem_stall = hz.MemAccessM && !hz.MemReadyM;
    assign pcwr      = hz.PCWrD | pend[0] | pend[1];
    assign stall_f   = ld_stall | pcwr | mem_stall;
    assign flush_d   = !mem_stall &
                       (pcwr | pend[2] | hz.BranchTakenE);
    assign flush_e   = !mem_stall & (ld_stall | hz.BranchTakenE);

    assign hz.StallF     = !reset & stall_f;
    assign hz.StallD     = !reset & (ld_stall | mem_stall);
    assign hz.StallE     = !reset & mem_stall;
    assign hz.StallM     = !reset & mem_stall;
    assign hz.FlushD     = reset | flush_d;
    assign hz.FlushE     = reset | flush_e;
    assign hz.FlushW     = reset | mem_stall;
    assign hz.ForwardE   = reset ? '0 : fwd;
    assign hz.MemTimeout = mem_timeout;
    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            pend        <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (!mem_stall)
                pend <= {pend[1],
                         pend[0] & hz.CondExE,
                         hz.PCWrD & !ld_stall & !hz.BranchTakenE};
            // wait_cnt counts consecutive stalled cycles, entry cycle included
            unique case (state)
                ST_RUN: begin
                    if (mem_stall) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WC_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!mem_stall) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WC_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
            if (mem_stall && wait_cnt == WC_MAX)
                mem_timeout <= 1'b1;
            if (stall_f && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if ((flush_d | flush_e) && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: one LDR_LAT=1/TIMEOUT=4 unit and
// one LDR_LAT=2 unit share the same pipeline inputs.
module tb_hazard_unit_mc;
    localparam int RA_W  = 4;
    localparam int NSRC  = 3;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.RA_W(RA_W), .NSRC(NSRC), .CNT_W(CNT_W)) h0 ();
    hazard_unit_mc_if #(.RA_W(RA_W), .NSRC(NSRC), .CNT_W(CNT_W)) h1 ();

    assign h1.RAD          = h0.RAD;
    assign h1.RAE          = h0.RAE;
    assign h1.WA3E         = h0.WA3E;
    assign h1.WA3M         = h0.WA3M;
    assign h1.WA3W         = h0.WA3W;
    assign h1.MemtoRegE    = h0.MemtoRegE;
    assign h1.MemtoRegM    = h0.MemtoRegM;
    assign h1.RegWriteM    = h0.RegWriteM;
    assign h1.RegWriteW    = h0.RegWriteW;
    assign h1.PCWrD        = h0.PCWrD;
    assign h1.CondExE      = h0.CondExE;
    assign h1.BranchTakenE = h0.BranchTakenE;
    assign h1.MemAccessM   = h0.MemAccessM;
    assign h1.MemReadyM    = h0.MemReadyM;

    hazard_unit_mc #(.RA_W(RA_W), .NSRC(NSRC), .LDR_LAT(1),
                     .PC_IDX(15), .TIMEOUT(4), .CNT_W(CNT_W))
        u0 (.clk(clk), .reset(reset), .hz(h0));
    hazard_unit_mc #(.RA_W(RA_W), .NSRC(NSRC), .LDR_LAT(2),
                     .PC_IDX(15), .TIMEOUT(64), .CNT_W(CNT_W))
        u1 (.clk(clk), .reset(reset), .hz(h1));

    typedef struct {
        bit          unit;
        string       name;
        logic [3:0]  stl;
        logic [2:0]  fl;
        logic [5:0]  fwd;
        bit          cf;
        bit          cx;
        logic        tmo;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    // stl = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
    task automatic push(input bit unit, input string name,
                        input logic [3:0] stl, input logic [2:0] fl,
                        input logic [5:0] fwd, input bit cf, input bit cx,
                        input logic tmo, input logic [15:0] sc,
                        input logic [15:0] fc);
        exp_t e;
        e.unit = unit; e.name = name; e.stl = stl; e.fl = fl;
        e.fwd = fwd; e.cf = cf; e.cx = cx;
        e.tmo = tmo; e.sc = sc; e.fc = fc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic ck(input bit unit, input string name,
                      input logic [3:0] stl, input logic [2:0] fl);
        push(unit, name, stl, fl, 6'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
    endtask

    task automatic ckx(input string name, input logic [3:0] stl,
                       input logic [2:0] fl, input logic tmo,
                       input logic [15:0] sc, input logic [15:0] fc);
        push(1'b0, name, stl, fl, 6'd0, 1'b0, 1'b1, tmo, sc, fc);
    endtask

    task automatic clr();
        h0.RAD = '0; h0.RAE = '0;
        h0.WA3E = '0; h0.WA3M = '0; h0.WA3W = '0;
        h0.MemtoRegE = 1'b0; h0.MemtoRegM = 1'b0;
        h0.RegWriteM = 1'b0; h0.RegWriteW = 1'b0;
        h0.PCWrD = 1'b0; h0.CondExE = 1'b0; h0.BranchTakenE = 1'b0;
        h0.MemAccessM = 1'b0; h0.MemReadyM = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [45:0] g, x, m;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.unit)
                g = {h1.StallF, h1.StallD, h1.StallE, h1.StallM,
                     h1.FlushD, h1.FlushE, h1.FlushW, h1.ForwardE,
                     h1.MemTimeout, h1.StallCount, h1.FlushCount};
            else
                g = {h0.StallF, h0.StallD, h0.StallE, h0.StallM,
                     h0.FlushD, h0.FlushE, h0.FlushW, h0.ForwardE,
                     h0.MemTimeout, h0.StallCount, h0.FlushCount};
            x = {e.stl, e.fl, e.fwd, e.tmo, e.sc, e.fc};
            m = {7'h7f, {6{e.cf}}, {33{e.cx}}};
            tests++;
            if (((g ^ x) & m) !== '0) begin
                fails++;
                $display("FAIL %s (u%0d): got %h want %h mask %h",
                         e.name, e.unit, g & m, x & m, m);
            end
        end
    end

    initial begin
        reset = 1'b1;
        clr();
        @(posedge clk);
        #1;
        ckx("rst_idle", 4'b0000, 3'b111, 1'b0, 16'd0, 16'd0);
        h0.RAE = 12'h001; h0.WA3M = 4'd1; h0.RegWriteM = 1'b1;
        h0.MemAccessM = 1'b1; h0.PCWrD = 1'b1;
        push(0, "rst_gate", 4'b0000, 3'b111, 6'd0, 1, 0, 0, 0, 0);
        reset = 1'b0;

        clr(); h0.RAE = 12'h001; h0.WA3M = 4'd1; h0.RegWriteM = 1'b1;
        push(0, "fwd_m", 4'b0000, 3'b000, 6'b000010, 1, 1, 0, 0, 0);
        clr(); h0.RAE = 12'h001; h0.WA3W = 4'd1; h0.RegWriteW = 1'b1;
        push(0, "fwd_w", 4'b0000, 3'b000, 6'b000001, 1, 0, 0, 0, 0);
        clr(); h0.RAE = 12'h3ff;
        h0.WA3M = 4'd15; h0.RegWriteM = 1'b1;
        h0.WA3W = 4'd15; h0.RegWriteW = 1'b1;
        push(0, "fwd_pc", 4'b0000, 3'b000, 6'b000000, 1, 0, 0, 0, 0);
        clr(); h0.RAE = 12'h500; h0.MemtoRegM = 1'b1;
        h0.WA3M = 4'd5; h0.RegWriteM = 1'b1;
        h0.WA3W = 4'd5; h0.RegWriteW = 1'b1;
        push(0, "fwd_prio", 4'b0000, 3'b000, 6'b100000, 1, 0, 0, 0, 0);
        push(1, "fwd_ld2", 4'b0000, 3'b000, 6'b010000, 1, 0, 0, 0, 0);

        clr(); h0.MemtoRegE = 1'b1; h0.WA3E = 4'd2; h0.RAD = 12'h020;
        ck(0, "ld_use", 4'b1100, 3'b010);
        clr(); h0.MemtoRegM = 1'b1; h0.WA3M = 4'd2; h0.RegWriteM = 1'b1;
        h0.RAD = 12'h020;
        ck(0, "ld_lat1_m", 4'b0000, 3'b000);
        clr(); h0.WA3W = 4'd2; h0.RegWriteW = 1'b1; h0.RAE = 12'h020;
        push(0, "ld_fwd_w", 4'b0000, 3'b000, 6'b000100, 1, 1, 0, 1, 1);

        clr(); h0.MemtoRegE = 1'b1; h0.WA3E = 4'd2; h0.RAD = 12'h020;
        ck(1, "ld2_e", 4'b1100, 3'b010);
        clr(); h0.MemtoRegM = 1'b1; h0.WA3M = 4'd2; h0.RegWriteM = 1'b1;
        h0.RAD = 12'h020;
        ck(1, "ld2_m", 4'b1100, 3'b010);
        clr(); h0.WA3W = 4'd2; h0.RegWriteW = 1'b1; h0.RAD = 12'h020;
        ck(1, "ld2_w", 4'b0000, 3'b000);
        clr(); h0.WA3W = 4'd2; h0.RegWriteW = 1'b1; h0.RAE = 12'h020;
        push(1, "ld2_fwd", 4'b0000, 3'b000, 6'b000100, 1, 0, 0, 0, 0);

        clr(); h0.PCWrD = 1'b1; h0.CondExE = 1'b1;
        ck(0, "pc1", 4'b1000, 3'b100);
        h0.PCWrD = 1'b0;
        ck(0, "pc2", 4'b1000, 3'b100);
        ck(0, "pc3", 4'b1000, 3'b100);
        ck(0, "pc4", 4'b0000, 3'b100);
        ckx("pc5", 4'b0000, 3'b000, 1'b0, 16'd5, 16'd6);

        clr(); h0.PCWrD = 1'b1;
        ck(0, "pcn1", 4'b1000, 3'b100);
        h0.PCWrD = 1'b0;
        ck(0, "pcn2", 4'b1000, 3'b100);
        ckx("pcn3", 4'b0000, 3'b000, 1'b0, 16'd7, 16'd8);

        clr(); h0.BranchTakenE = 1'b1; h0.MemtoRegE = 1'b1;
        h0.WA3E = 4'd3; h0.RAD = 12'h003;
        ck(0, "br_ld", 4'b1100, 3'b110);
        h0.MemAccessM = 1'b1;
        ck(0, "br_ld_mem", 4'b1111, 3'b001);
        clr();
        ckx("post_br", 4'b0000, 3'b000, 1'b0, 16'd9, 16'd9);

        clr(); h0.PCWrD = 1'b1; h0.CondExE = 1'b1;
        ck(0, "pc_pre_mem", 4'b1000, 3'b100);
        h0.PCWrD = 1'b0; h0.MemAccessM = 1'b1; h0.MemReadyM = 1'b0;
        ck(0, "mem1", 4'b1111, 3'b001);
        ck(0, "mem2", 4'b1111, 3'b001);
        ck(0, "mem3", 4'b1111, 3'b001);
        ckx("mem4", 4'b1111, 3'b001, 1'b0, 16'd13, 16'd10);
        ckx("mem5", 4'b1111, 3'b001, 1'b1, 16'd14, 16'd10);
        h0.MemReadyM = 1'b1;
        ckx("mem_rdy", 4'b1000, 3'b100, 1'b1, 16'd15, 16'd10);
        h0.MemAccessM = 1'b0; h0.MemReadyM = 1'b0;
        ck(0, "pc_resume", 4'b1000, 3'b100);
        ckx("pc_tail", 4'b0000, 3'b100, 1'b1, 16'd17, 16'd12);
        ckx("pc_done", 4'b0000, 3'b000, 1'b1, 16'd17, 16'd13);

        h0.PCWrD = 1'b1;
        ck(0, "h_pc", 4'b1000, 3'b100);
        h0.PCWrD = 1'b0; h0.MemAccessM = 1'b1;
        ck(0, "h_mem1", 4'b1111, 3'b001);
        ckx("h_mem2", 4'b1111, 3'b001, 1'b1, 16'd19, 16'd14);
        reset = 1'b1;
        h0.RAE = 12'h001; h0.WA3M = 4'd1; h0.RegWriteM = 1'b1;
        push(0, "rst_wait", 4'b0000, 3'b111, 6'd0, 1, 1, 1, 20, 14);
        reset = 1'b0;
        clr();
        push(0, "rst_after", 4'b0000, 3'b000, 6'd0, 1, 1, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
